// File: rtl/sdram_burst_responder_if.sv
// Cache-fill and backing-memory signal bundle for sdram_burst_responder.
// The slave modport is the responder; master is the cache/memory side.
interface sdram_burst_responder_if;
   logic        sdram_req;
   logic [31:0] sdram_addr;
   logic        sdram_fill;
   logic [31:0] data_to_cache;
   logic        busy;
   logic        error;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_data;

   modport slave (
      input  sdram_req, sdram_addr, mem_ack, mem_data,
      output sdram_fill, data_to_cache, busy, error, mem_req, mem_addr
   );

   modport master (
      output sdram_req, sdram_addr, mem_ack, mem_data,
      input  sdram_fill, data_to_cache, busy, error, mem_req, mem_addr
   );
endinterface

// File: rtl/sdram_burst_responder.sv
// Fetches an 8-word line from a single-word memory port into a buffer, then
// streams it to the cache critical-word-first with a one-cycle fill pulse.
module sdram_burst_responder #(
   parameter int MEM_TIMEOUT = 255
) (
   input logic                    clk,
   input logic                    reset,
   sdram_burst_responder_if.slave bus
);

   localparam int TW = $clog2(MEM_TIMEOUT + 2);

   typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

   state_t         state_q, state_d;
   logic [26:0]    line_q, line_d;
   logic [2:0]     crit_q, crit_d;
   logic [2:0]     fidx_q, fidx_d;
   logic [2:0]     fcnt_q, fcnt_d;
   logic [3:0]     scnt_q, scnt_d;
   logic [TW-1:0]  wcnt_q, wcnt_d;
   logic           busy_q, busy_d;
   logic           error_q, error_d;
   logic           mem_req_q, mem_req_d;
   logic [31:0]    mem_addr_q, mem_addr_d;
   logic           fill_q, fill_d;
   logic [31:0]    data_q, data_d;
   logic [2:0]     fidx_nxt;
   logic [2:0]     ridx;
   logic [31:0]    buf_q [8];

   always_comb begin
      // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
      state_d    = state_q;
      line_d     = line_q;
      crit_d     = crit_q;
      fidx_d     = fidx_q;
      fcnt_d     = fcnt_q;
      scnt_d     = scnt_q;
      wcnt_d     = wcnt_q;
      busy_d     = busy_q;
      error_d    = error_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      fill_d     = 1'b0;
      data_d     = data_q;
      fidx_nxt   = fidx_q + 3'd1;
      ridx       = crit_q + scnt_q[2:0];

      case (state_q)
         IDLE: begin
            if (bus.sdram_req) begin
               line_d     = bus.sdram_addr[31:5];
               crit_d     = bus.sdram_addr[4:2];
               fidx_d     = bus.sdram_addr[4:2];
               fcnt_d     = 3'd0;
               wcnt_d     = '0;
               busy_d     = 1'b1;
               mem_req_d  = 1'b1;
               mem_addr_d = {bus.sdram_addr[31:2], 2'b00};
               state_d    = FETCH;
            end
         end

         FETCH: begin
            if (bus.mem_ack) begin
               fidx_d     = fidx_nxt;
               fcnt_d     = fcnt_q + 3'd1;
               wcnt_d     = '0;
               mem_addr_d = {line_q, fidx_nxt, 2'b00};
               if (fcnt_q == 3'd7) begin
                  mem_req_d = 1'b0;
                  // A withdrawn request still drains the burst, but the line is dropped.
                  if (bus.sdram_req) begin
                     scnt_d  = 4'd0;
                     state_d = STREAM;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = IDLE;
                  end
               end
            end else if (MEM_TIMEOUT != 0 && wcnt_q == TW'(MEM_TIMEOUT - 1)) begin
               error_d   = 1'b1;
               mem_req_d = 1'b0;
               busy_d    = 1'b0;
               state_d   = IDLE;
            end else begin
               wcnt_d = wcnt_q + TW'(1);
            end
         end

         STREAM: begin
            // scnt 0..7 registers words S0..S7; scnt 8 is the cycle S7 is on the bus.
            if (scnt_q == 4'd8) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               fill_d = (scnt_q == 4'd0);
               data_d = buf_q[ridx];
               scnt_d = scnt_q + 4'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         line_q     <= '0;
         crit_q     <= '0;
         fidx_q     <= '0;
         fcnt_q     <= '0;
         scnt_q     <= '0;
         wcnt_q     <= '0;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         fill_q     <= 1'b0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         line_q     <= line_d;
         crit_q     <= crit_d;
         fidx_q     <= fidx_d;
         fcnt_q     <= fcnt_d;
         scnt_q     <= scnt_d;
         wcnt_q     <= wcnt_d;
         busy_q     <= busy_d;
         error_q    <= error_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         fill_q     <= fill_d;
         data_q     <= data_d;
      end
   end

   // NOTE: the line buffer is never read before it is written, so it has no reset.
   always_ff @(posedge clk) begin
      if (state_q == FETCH && bus.mem_ack) buf_q[fidx_q] <= bus.mem_data;
   end

   assign bus.sdram_fill    = fill_q;
   assign bus.data_to_cache = data_q;
   assign bus.busy          = busy_q;
   assign bus.error         = error_q;
   assign bus.mem_req       = mem_req_q;
   assign bus.mem_addr      = mem_addr_q;

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Directed bench for sdram_burst_responder: one instance with the default
// timeout for the fill scenarios, one with MEM_TIMEOUT=4 for the abort case.
module tb_sdram_burst_responder;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sdram_burst_responder_if if_a ();
   sdram_burst_responder_if if_b ();

   sdram_burst_responder u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a.slave)
   );

   sdram_burst_responder #(.MEM_TIMEOUT(4)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b.slave)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] a_base   = 32'h0;
   bit          a_rand   = 1'b0;
   int          a_gap    = 0;
   logic [31:0] a_log [$];
   int          a_fills  = 0;
   int          b_fills  = 0;
   bit          b_ack_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Memory model for instance A: decides at negedge whether to ack on the next posedge.
   initial begin
      if_a.mem_ack  = 1'b0;
      if_a.mem_data = 32'h0;
      forever begin
         @(negedge clk);
         if_a.mem_ack = 1'b0;
         if (if_a.mem_req === 1'b1) begin
            if (a_gap > 0) begin
               a_gap--;
            end else begin
               if_a.mem_ack  = 1'b1;
               if_a.mem_data = a_base + {29'd0, if_a.mem_addr[4:2]};
               a_log.push_back(if_a.mem_addr);
               a_gap = a_rand ? int'($urandom_range(0, 5)) : 0;
            end
         end
      end
   end

   initial begin
      if_b.mem_ack  = 1'b0;
      if_b.mem_data = 32'h0;
      forever begin
         @(negedge clk);
         if_b.mem_ack  = b_ack_en && (if_b.mem_req === 1'b1);
         if_b.mem_data = 32'hD0 + {29'd0, if_b.mem_addr[4:2]};
      end
   end

   always @(negedge clk) begin
      if (if_a.sdram_fill === 1'b1) a_fills++;
      if (if_b.sdram_fill === 1'b1) b_fills++;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic start_req(input logic [31:0] addr, input logic [31:0] base,
                            input bit rnd, output int fills0);
      a_base = base;
      a_rand = rnd;
      a_gap  = 0;
      a_log.delete();
      fills0 = a_fills;
      if_a.sdram_addr = addr;
      if_a.sdram_req  = 1'b1;
   endtask

   // Steps until the fill pulse is seen; lat counts cycles from request to fill.
   task automatic wait_fill(input string tag, output int lat);
      lat = 0;
      for (int i = 1; i <= 120; i++) begin
         step();
         if (if_a.sdram_fill === 1'b1) begin
            lat = i;
            break;
         end
      end
      check({tag, "_fill_seen"}, {31'd0, lat != 0}, 32'd1);
      if_a.sdram_req = 1'b0;
   endtask

   task automatic check_stream(input string tag, input logic [31:0] addr,
                               input logic [31:0] base, input int n);
      logic [2:0] idx;
      for (int k = 0; k < n; k++) begin
         if (k > 0) begin
            step();
            check($sformatf("%s_fill_low%0d", tag, k), {31'd0, if_a.sdram_fill}, 32'd0);
         end
         idx = addr[4:2] + 3'(k);
         check($sformatf("%s_word%0d", tag, k), if_a.data_to_cache, base + {29'd0, idx});
      end
   endtask

   task automatic finish_stream(input string tag, input int fills0);
      step();
      check({tag, "_busy_done"}, {31'd0, if_a.busy}, 32'd0);
      check({tag, "_one_fill"}, 32'(a_fills - fills0), 32'd1);
      check({tag, "_mem_req_idle"}, {31'd0, if_a.mem_req}, 32'd0);
   endtask

   initial begin
      int          f0;
      int          lat;
      logic [31:0] exp_addr;

      reset = 1'b1;
      if_a.sdram_req  = 1'b0;
      if_a.sdram_addr = 32'h0;
      if_b.sdram_req  = 1'b0;
      if_b.sdram_addr = 32'h0;
      repeat (3) step();

      check("rst_fill",  {31'd0, if_a.sdram_fill}, 32'd0);
      check("rst_data",  if_a.data_to_cache, 32'd0);
      check("rst_busy",  {31'd0, if_a.busy}, 32'd0);
      check("rst_error", {31'd0, if_a.error}, 32'd0);
      check("rst_mreq",  {31'd0, if_a.mem_req}, 32'd0);
      check("rst_maddr", if_a.mem_addr, 32'd0);
      check("rst_b_err", {31'd0, if_b.error}, 32'd0);
      reset = 1'b0;
      step();

      // 1: critical word 0, ack every cycle.
      start_req(32'h0000_1000, 32'hA0, 1'b0, f0);
      step();
      check("t1_busy_on", {31'd0, if_a.busy}, 32'd1);
      check("t1_mreq_on", {31'd0, if_a.mem_req}, 32'd1);
      check("t1_maddr0",  if_a.mem_addr, 32'h0000_1000);
      lat = 0;
      for (int i = 2; i <= 40; i++) begin
         step();
         if (if_a.sdram_fill === 1'b1) begin
            lat = i;
            break;
         end
      end
      if_a.sdram_req = 1'b0;
      check("t1_latency", 32'(lat), 32'd10);
      check_stream("t1", 32'h0000_1000, 32'hA0, 8);
      finish_stream("t1", f0);

      // 2: critical word 5, wrap order on both address and data.
      start_req(32'h0000_1014, 32'hB0, 1'b0, f0);
      wait_fill("t2", lat);
      check("t2_latency", 32'(lat), 32'd10);
      check("t2_nacks", 32'(a_log.size()), 32'd8);
      for (int k = 0; k < 8 && k < a_log.size(); k++) begin
         exp_addr = 32'h0000_1000 + 32'(((5 + k) % 8) * 4);
         check($sformatf("t2_maddr%0d", k), a_log[k], exp_addr);
      end
      check_stream("t2", 32'h0000_1014, 32'hB0, 8);
      finish_stream("t2", f0);

      // 3: random ack gaps of 0-5 cycles.
      start_req(32'h0000_2008, 32'hC0, 1'b1, f0);
      wait_fill("t3", lat);
      check_stream("t3", 32'h0000_2008, 32'hC0, 8);
      finish_stream("t3", f0);

      // 4: request withdrawn after the third ack.
      start_req(32'h0000_4008, 32'hE0, 1'b0, f0);
      for (int i = 0; i < 20 && a_log.size() < 3; i++) step();
      step();
      if_a.sdram_req = 1'b0;
      for (int i = 0; i < 40 && if_a.busy !== 1'b0; i++) step();
      check("t4_busy_off", {31'd0, if_a.busy}, 32'd0);
      check("t4_mreq_off", {31'd0, if_a.mem_req}, 32'd0);
      check("t4_nacks", 32'(a_log.size()), 32'd8);
      if (a_log.size() == 8) check("t4_last_addr", a_log[7], 32'h0000_4004);
      repeat (12) step();
      check("t4_no_fill", 32'(a_fills - f0), 32'd0);

      // 5: MEM_TIMEOUT=4 with no ack, then a normal request on the same instance.
      b_ack_en = 1'b0;
      f0 = b_fills;
      if_b.sdram_addr = 32'h0000_3000;
      if_b.sdram_req  = 1'b1;
      step();
      check("t5_mreq_on", {31'd0, if_b.mem_req}, 32'd1);
      check("t5_busy_on", {31'd0, if_b.busy}, 32'd1);
      repeat (3) step();
      check("t5_err_early", {31'd0, if_b.error}, 32'd0);
      step();
      check("t5_err_set",   {31'd0, if_b.error}, 32'd1);
      check("t5_mreq_drop", {31'd0, if_b.mem_req}, 32'd0);
      check("t5_busy_drop", {31'd0, if_b.busy}, 32'd0);
      if_b.sdram_req = 1'b0;
      repeat (5) step();
      check("t5_no_fill", 32'(b_fills - f0), 32'd0);

      b_ack_en = 1'b1;
      if_b.sdram_addr = 32'h0000_3008;
      if_b.sdram_req  = 1'b1;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (if_b.sdram_fill === 1'b1) begin
            lat = i;
            break;
         end
      end
      if_b.sdram_req = 1'b0;
      check("t5_latency", 32'(lat), 32'd10);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) step();
         check($sformatf("t5_word%0d", k), if_b.data_to_cache, 32'hD0 + 32'((2 + k) % 8));
      end
      step();
      check("t5_busy_done", {31'd0, if_b.busy}, 32'd0);
      check("t5_err_sticky", {31'd0, if_b.error}, 32'd1);
      b_ack_en = 1'b0;

      // 6: reset during stream word S3, then a fresh request.
      start_req(32'h0000_5010, 32'h50, 1'b0, f0);
      wait_fill("t6", lat);
      check_stream("t6", 32'h0000_5010, 32'h50, 4);
      reset = 1'b1;
      #1;
      check("t6_rst_fill",  {31'd0, if_a.sdram_fill}, 32'd0);
      check("t6_rst_data",  if_a.data_to_cache, 32'd0);
      check("t6_rst_busy",  {31'd0, if_a.busy}, 32'd0);
      check("t6_rst_error", {31'd0, if_a.error}, 32'd0);
      check("t6_rst_mreq",  {31'd0, if_a.mem_req}, 32'd0);
      check("t6_rst_maddr", if_a.mem_addr, 32'd0);
      check("t6_rst_b_err", {31'd0, if_b.error}, 32'd0);
      step();
      step();
      reset = 1'b0;
      f0 = a_fills;
      repeat (12) step();
      check("t6_no_fill", 32'(a_fills - f0), 32'd0);

      start_req(32'h0000_6000, 32'h60, 1'b0, f0);
      wait_fill("t6b", lat);
      check("t6b_latency", 32'(lat), 32'd10);
      check_stream("t6b", 32'h0000_6000, 32'h60, 8);
      finish_stream("t6b", f0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, %0d checks done", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
